// File: rtl/midi_msg_parser.sv
// MIDI channel-voice parser: assembles Note On/Off events from the receiver byte stream, tracks the held note.
// Latency: NOTE_VALID and the NOTE_*/HELD_* outputs update one cycle after the MIDI_RDY of the final data byte.
// Backpressure: none; one byte is accepted on every MIDI_RDY cycle, including back-to-back strobes.
module midi_msg_parser #(
    parameter bit       CH_FILTER_EN = 1'b0,
    parameter bit [3:0] CH_SEL       = 4'd0
) (
    input  logic       clk500kHz,
    input  logic       RESET,
    input  logic       MIDI_RDY,
    input  logic [7:0] MIDI_BYTE,
    output logic       NOTE_VALID,
    output logic       NOTE_ON,
    output logic [6:0] NOTE_NUM,
    output logic [6:0] VELOCITY,
    output logic [3:0] CHANNEL,
    output logic       HELD_VALID,
    output logic [6:0] HELD_NOTE
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] rs_q;          // running status {type, channel}
    logic [6:0] d1_q;          // first data byte of the message in progress
    logic       note_valid_q;
    logic       note_on_q;
    logic [6:0] note_num_q;
    logic [6:0] velocity_q;
    logic [3:0] channel_q;
    logic       held_valid_q;
    logic [6:0] held_note_q;

    logic [3:0] msg_type;
    logic [3:0] msg_ch;
    logic       is_realtime;
    logic       is_syscommon;
    logic       is_status;
    logic       two_data;
    logic       is_note;
    logic       ch_ok;
    logic       note_on_d;
    logic [6:0] velocity_d;

    // Decode the incoming byte and the running status; the data-byte fields assume
    // MIDI_BYTE is the second data byte, which is the only case where they are used.
    always_comb begin
        msg_type     = rs_q[7:4];
        msg_ch       = rs_q[3:0];
        is_realtime  = (MIDI_BYTE[7:3] == 5'b11111);
        is_syscommon = (MIDI_BYTE[7:3] == 5'b11110);
        is_status    = MIDI_BYTE[7];
        two_data     = (msg_type == 4'h8) || (msg_type == 4'h9) || (msg_type == 4'hA) ||
                       (msg_type == 4'hB) || (msg_type == 4'hE);
        is_note      = (msg_type == 4'h8) || (msg_type == 4'h9);
        ch_ok        = (CH_FILTER_EN == 1'b0) || (msg_ch == CH_SEL);
        note_on_d    = (msg_type == 4'h9) && (MIDI_BYTE[6:0] != 7'd0);
        velocity_d   = (msg_type == 4'h9) ? MIDI_BYTE[6:0] : 7'd0;
    end

    // Parser FSM with registered event outputs and held-note tracker.
    always_ff @(posedge clk500kHz) begin
        if (RESET) begin
            state_q      <= IDLE;
            rs_q         <= 8'd0;
            d1_q         <= 7'd0;
            note_valid_q <= 1'b0;
            note_on_q    <= 1'b0;
            note_num_q   <= 7'd0;
            velocity_q   <= 7'd0;
            channel_q    <= 4'd0;
            held_valid_q <= 1'b0;
            held_note_q  <= 7'd0;
        end else begin
            note_valid_q <= 1'b0;
            // Real-time bytes may appear anywhere and must leave the parse untouched.
            if (MIDI_RDY && !is_realtime) begin
                if (is_syscommon) begin
                    rs_q    <= 8'd0;
                    state_q <= IDLE;
                end else if (is_status) begin
                    // A new status also aborts any partially received message.
                    rs_q    <= MIDI_BYTE;
                    state_q <= WAIT_D1;
                end else begin
                    case (state_q)
                        WAIT_D1: begin
                            d1_q <= MIDI_BYTE[6:0];
                            // One-data-byte messages (C/D) complete here and are discarded.
                            state_q <= two_data ? WAIT_D2 : WAIT_D1;
                        end
                        WAIT_D2: begin
                            state_q <= WAIT_D1;
                            if (is_note && ch_ok) begin
                                note_valid_q <= 1'b1;
                                note_on_q    <= note_on_d;
                                note_num_q   <= d1_q;
                                velocity_q   <= velocity_d;
                                channel_q    <= msg_ch;
                                if (note_on_d) begin
                                    held_valid_q <= 1'b1;
                                    held_note_q  <= d1_q;
                                end else if (held_valid_q && (d1_q == held_note_q)) begin
                                    held_valid_q <= 1'b0;
                                end
                            end
                        end
                        default: begin
                            // IDLE: no running status, data byte dropped.
                            state_q <= IDLE;
                        end
                    endcase
                end
            end
        end
    end

    assign NOTE_VALID = note_valid_q;
    assign NOTE_ON    = note_on_q;
    assign NOTE_NUM   = note_num_q;
    assign VELOCITY   = velocity_q;
    assign CHANNEL    = channel_q;
    assign HELD_VALID = held_valid_q;
    assign HELD_NOTE  = held_note_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
`timescale 1ns/1ps
module tb_midi_msg_parser;

    logic       clk500kHz;
    logic       RESET;
    logic       MIDI_RDY;
    logic [7:0] MIDI_BYTE;

    logic       nv0, on0, hv0;
    logic [6:0] num0, vel0, hn0;
    logic [3:0] ch0;
    logic       nv1, on1, hv1;
    logic [6:0] num1, vel1, hn1;
    logic [3:0] ch1;

    int errors = 0;
    int checks = 0;
    int ev0 = 0;
    int ev1 = 0;
    int base0;
    int base1;

    midi_msg_parser dut0 (
        .clk500kHz(clk500kHz), .RESET(RESET), .MIDI_RDY(MIDI_RDY), .MIDI_BYTE(MIDI_BYTE),
        .NOTE_VALID(nv0), .NOTE_ON(on0), .NOTE_NUM(num0), .VELOCITY(vel0),
        .CHANNEL(ch0), .HELD_VALID(hv0), .HELD_NOTE(hn0)
    );

    midi_msg_parser #(.CH_FILTER_EN(1'b1), .CH_SEL(4'd2)) dut1 (
        .clk500kHz(clk500kHz), .RESET(RESET), .MIDI_RDY(MIDI_RDY), .MIDI_BYTE(MIDI_BYTE),
        .NOTE_VALID(nv1), .NOTE_ON(on1), .NOTE_NUM(num1), .VELOCITY(vel1),
        .CHANNEL(ch1), .HELD_VALID(hv1), .HELD_NOTE(hn1)
    );

    initial clk500kHz = 1'b0;
    always #1000 clk500kHz = ~clk500kHz;

    always @(negedge clk500kHz) begin
        if (nv0 === 1'b1) ev0 <= ev0 + 1;
        if (nv1 === 1'b1) ev1 <= ev1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] b);
        @(negedge clk500kHz);
        MIDI_RDY  = 1'b1;
        MIDI_BYTE = b;
    endtask

    task automatic idle();
        @(negedge clk500kHz);
        MIDI_RDY  = 1'b0;
        MIDI_BYTE = 8'h00;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_nv"}, {31'd0, nv0}, 32'd0);
        chk({tag, "_on"}, {31'd0, on0}, 32'd0);
        chk({tag, "_num"}, {25'd0, num0}, 32'd0);
        chk({tag, "_vel"}, {25'd0, vel0}, 32'd0);
        chk({tag, "_ch"}, {28'd0, ch0}, 32'd0);
        chk({tag, "_hv"}, {31'd0, hv0}, 32'd0);
        chk({tag, "_hn"}, {25'd0, hn0}, 32'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        MIDI_RDY  = 1'b0;
        MIDI_BYTE = 8'h00;
        repeat (3) @(negedge clk500kHz);
        RESET = 1'b0;
        chk_zero("reset");

        // 90 3C 64 back-to-back
        put(8'h90); put(8'h3C); put(8'h64); idle();
        chk("on1_nv",  {31'd0, nv0}, 32'd1);
        chk("on1_on",  {31'd0, on0}, 32'd1);
        chk("on1_num", {25'd0, num0}, 32'h3C);
        chk("on1_vel", {25'd0, vel0}, 32'h64);
        chk("on1_ch",  {28'd0, ch0}, 32'd0);
        chk("on1_hv",  {31'd0, hv0}, 32'd1);
        chk("on1_hn",  {25'd0, hn0}, 32'h3C);
        idle();
        chk("on1_pulse", {31'd0, nv0}, 32'd0);
        chk("on1_hold_num", {25'd0, num0}, 32'h3C);

        // running status 3E 50
        put(8'h3E); put(8'h50); idle();
        chk("rs_nv",  {31'd0, nv0}, 32'd1);
        chk("rs_on",  {31'd0, on0}, 32'd1);
        chk("rs_num", {25'd0, num0}, 32'h3E);
        chk("rs_hn",  {25'd0, hn0}, 32'h3E);

        // 3C 00: note off of a non-held note
        put(8'h3C); put(8'h00); idle();
        chk("off1_nv",  {31'd0, nv0}, 32'd1);
        chk("off1_on",  {31'd0, on0}, 32'd0);
        chk("off1_num", {25'd0, num0}, 32'h3C);
        chk("off1_vel", {25'd0, vel0}, 32'd0);
        chk("off1_hv",  {31'd0, hv0}, 32'd1);
        chk("off1_hn",  {25'd0, hn0}, 32'h3E);

        // 3E 00: releases held note
        put(8'h3E); put(8'h00); idle();
        chk("off2_nv", {31'd0, nv0}, 32'd1);
        chk("off2_hv", {31'd0, hv0}, 32'd0);

        // 93 40 F8 7F: clock byte mid-message
        put(8'h93); put(8'h40); put(8'hF8); put(8'h7F); idle();
        chk("rt_nv",  {31'd0, nv0}, 32'd1);
        chk("rt_on",  {31'd0, on0}, 32'd1);
        chk("rt_num", {25'd0, num0}, 32'h40);
        chk("rt_vel", {25'd0, vel0}, 32'h7F);
        chk("rt_ch",  {28'd0, ch0}, 32'd3);
        chk("rt_hv",  {31'd0, hv0}, 32'd1);
        chk("rt_hn",  {25'd0, hn0}, 32'h40);
        idle(); idle();

        // unsupported messages produce no events
        base0 = ev0;
        put(8'hB0); put(8'h07); put(8'h64);
        put(8'hC5); put(8'h10);
        put(8'hE0); put(8'h00); put(8'h40);
        idle(); idle(); idle();
        chk("unsup_events", ev0 - base0, 32'd0);
        chk("unsup_hold_num", {25'd0, num0}, 32'h40);
        chk("unsup_hv", {31'd0, hv0}, 32'd1);

        // 81 3C 40: type-8 note off reports velocity 0
        put(8'h81); put(8'h3C); put(8'h40); idle();
        chk("n8_nv",  {31'd0, nv0}, 32'd1);
        chk("n8_on",  {31'd0, on0}, 32'd0);
        chk("n8_num", {25'd0, num0}, 32'h3C);
        chk("n8_vel", {25'd0, vel0}, 32'd0);
        chk("n8_ch",  {28'd0, ch0}, 32'd1);
        chk("n8_hv",  {31'd0, hv0}, 32'd1);

        // data without running status after reset
        @(negedge clk500kHz); RESET = 1'b1;
        @(negedge clk500kHz); RESET = 1'b0;
        idle(); idle();
        base0 = ev0;
        put(8'h3C); put(8'h64); idle(); idle(); idle();
        chk("nors_events", ev0 - base0, 32'd0);

        // system common clears running status
        put(8'h90); put(8'h3C); put(8'hF0); put(8'h64); idle();
        put(8'h3C); put(8'h64); idle(); idle(); idle();
        chk("syscom_events", ev0 - base0, 32'd0);
        chk("syscom_hv", {31'd0, hv0}, 32'd0);

        // channel filter on dut1 (channel 2 only)
        idle();
        base1 = ev1;
        put(8'h91); put(8'h3C); put(8'h64); idle();
        chk("filt_drop_nv", {31'd0, nv1}, 32'd0);
        chk("filt_nofilt_nv", {31'd0, nv0}, 32'd1);
        idle(); idle();
        chk("filt_drop_events", ev1 - base1, 32'd0);
        put(8'h92); put(8'h3C); put(8'h64); idle();
        chk("filt_pass_nv",  {31'd0, nv1}, 32'd1);
        chk("filt_pass_ch",  {28'd0, ch1}, 32'd2);
        chk("filt_pass_num", {25'd0, num1}, 32'h3C);
        chk("filt_pass_hv",  {31'd0, hv1}, 32'd1);
        idle(); idle();

        // reset mid-message, coinciding with the final data byte
        chk("pre_rst_hv", {31'd0, hv0}, 32'd1);
        put(8'h90); put(8'h3C);
        @(negedge clk500kHz);
        RESET = 1'b1; MIDI_RDY = 1'b1; MIDI_BYTE = 8'h64;
        @(negedge clk500kHz);
        RESET = 1'b0; MIDI_RDY = 1'b0; MIDI_BYTE = 8'h00;
        chk_zero("midrst");
        idle();
        base0 = ev0;
        put(8'h64); idle(); idle(); idle();
        chk("midrst_events", ev0 - base0, 32'd0);
        chk("midrst_hv", {31'd0, hv0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
